gmii_rx_video: RTL and testbench

Receive-side counterpart of the video GMII transmitter. It sits on the Ethernet PHY GMII receive interface, locks onto frames, and filters for the video UDP stream by destination MAC, EtherType, IP protocol and UDP port. From each accepted frame it extracts the line number and the YCbCr pixel payload, and streams pixels as 16-bit words to the display-side line buffer. Frame integrity (FCS, length, rx_er) is reported at end of frame so the buffer can commit or discard the line.

---
 rtl/gmii_rx_video.sv | 162 ++++++++++++++++
 tb/tb_gmii_rx_video.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_video.sv
// gmii_rx_video: GMII receiver that filters the video UDP stream into line headers and 16-bit pixel words
//   rx_clk, sys_rst     : clock, asynchronous active-high reset
//   id                  : board id, subtracted from the low byte of MY_MAC
//   rx_dv, rx_er, rxd   : GMII receive interface
//   line_start, line_y  : line header pulse and held line number
//   pix_valid, pix_data : pixel pair pulse and {first, second} byte
//   frame_ok, frame_err : end-of-frame status pulses; drop_cnt counts frame_err, saturating
//   RX_CRC_CHECK_EN     : when defined the FCS is checked and a CRC mismatch reports frame_err
module gmii_rx_video #(
  parameter logic [47:0] MY_MAC = 48'h002345678902,
  parameter logic [15:0] UDP_PORT = 16'h3039,
  parameter int PIX_BYTES = 1280
) (
  input  logic        rx_clk,
  input  logic        sys_rst,
  input  logic        id,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        line_start,
  output logic [10:0] line_y,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] drop_cnt
);
  typedef enum logic [2:0] {IDLE, PRE, HDR, LINE, PIX, FCS, END, DROP} state_t;
  state_t state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0] hi_q, hi_d;
  logic fresh_q, fresh_d;
  logic line_start_q, line_start_d;
  logic [10:0] line_y_q, line_y_d;
  logic pix_valid_q, pix_valid_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic frame_ok_q, frame_ok_d;
  logic frame_err_q, frame_err_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [47:0] mac_acc;
  logic [7:0] hdr_exp;
  logic hdr_chk, accepted, crc_good;
  assign mac_acc = {MY_MAC[47:8], MY_MAC[7:0] - {7'd0, id}};
  assign hdr_chk = cnt_q < 11'd6 || cnt_q == 11'd12 || cnt_q == 11'd13 || cnt_q == 11'd23 ||
                   cnt_q == 11'd36 || cnt_q == 11'd37;
  assign hdr_exp = cnt_q < 11'd6 ? 8'(mac_acc >> {3'd5 - cnt_q[2:0], 3'b000}) :
                   cnt_q == 11'd12 ? 8'h08 :
                   cnt_q == 11'd23 ? 8'h11 :
                   cnt_q == 11'd36 ? UDP_PORT[15:8] :
                   cnt_q == 11'd37 ? UDP_PORT[7:0] : 8'h00;
  // errors only count once the UDP port bytes have matched
  assign accepted = state_q != HDR || cnt_q > 11'd37;
`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;
  // data enters LSB first; running the FCS through leaves the fixed residue
  always_comb begin
    crc_d = state_q == PRE ? 32'hFFFFFFFF : crc_q;
    if (state_q inside {HDR, LINE, PIX, FCS, END})
      for (int i = 0; i < 8; i++)
        crc_d = {crc_d[30:0], 1'b0} ^ ((crc_d[31] ^ rxd[i]) ? 32'h04C11DB7 : 32'h0);
  end
  always_ff @(posedge rx_clk or posedge sys_rst)
    if (sys_rst) crc_q <= 32'hFFFFFFFF;
    else crc_q <= crc_d;
  assign crc_good = crc_q == 32'hC704DD7B;
`else
  assign crc_good = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    fresh_d = 1'b0;
    line_y_d = line_y_q;
    pix_data_d = pix_data_q;
    line_start_d = 1'b0;
    pix_valid_d = 1'b0;
    frame_ok_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      // right after reset rx_dv may already be mid-frame, so wait for a gap
      IDLE: if (rx_dv) state_d = (rxd == 8'h55 && !fresh_q) ? PRE : DROP;
      PRE: begin
        cnt_d = '0;
        state_d = !rx_dv ? IDLE : rxd == 8'hD5 ? HDR : rxd == 8'h55 ? PRE : DROP;
      end
      DROP: if (!rx_dv) state_d = IDLE;
      default: begin
        cnt_d = cnt_q + 11'd1;
        hi_d = rxd;
        if (!rx_dv || rx_er) begin
          state_d = rx_dv ? DROP : IDLE;
          frame_ok_d = state_q == END && !rx_dv && crc_good;
          frame_err_d = accepted && !frame_ok_d;
        end else begin
          case (state_q)
            HDR:
              if (hdr_chk && rxd != hdr_exp) state_d = DROP;
              else if (cnt_q == 11'd41) begin
                state_d = LINE;
                cnt_d = '0;
              end
            LINE:
              if (cnt_q[0]) begin
                state_d = PIX;
                cnt_d = '0;
                line_start_d = 1'b1;
                line_y_d = {hi_q[2:0], rxd};
              end
            PIX: begin
              pix_valid_d = cnt_q[0];
              pix_data_d = cnt_q[0] ? {hi_q, rxd} : pix_data_q;
              if (cnt_q == 11'(PIX_BYTES - 1)) begin
                state_d = FCS;
                cnt_d = '0;
              end
            end
            FCS: if (cnt_q == 11'd3) state_d = END;
            default: begin
              state_d = DROP;
              frame_err_d = 1'b1;
            end
          endcase
        end
      end
    endcase
    drop_cnt_d = drop_cnt_q + {15'd0, frame_err_d && drop_cnt_q != 16'hFFFF};
  end
  always_ff @(posedge rx_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      fresh_q <= 1'b1;
      line_start_q <= 1'b0;
      line_y_q <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q <= '0;
      frame_ok_q <= 1'b0;
      frame_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      fresh_q <= fresh_d;
      line_start_q <= line_start_d;
      line_y_q <= line_y_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q <= pix_data_d;
      frame_ok_q <= frame_ok_d;
      frame_err_q <= frame_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  assign line_start = line_start_q;
  assign line_y = line_y_q;
  assign pix_valid = pix_valid_q;
  assign pix_data = pix_data_q;
  assign frame_ok = frame_ok_q;
  assign frame_err = frame_err_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_gmii_rx_video.sv
// tb_gmii_rx_video: table-driven frame scenarios with a pixel scoreboard for gmii_rx_video
module tb_gmii_rx_video;
  localparam int PB = 1280;
  localparam int HL = 44;
`ifdef RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  typedef struct {
    bit          id;
    logic [7:0]  mac_lo;
    logic [15:0] port;
    logic [15:0] line;
    int          flip;
    int          er_at;
    int          cut_at;
    bit          extra;
    int          gap;
    bit          acc;
    bit          ok;
    bit          err;
  } frame_t;
  logic rx_clk = 1'b0, sys_rst = 1'b1, id = 1'b0, rx_dv = 1'b0, rx_er = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic line_start, pix_valid, frame_ok, frame_err;
  logic [10:0] line_y;
  logic [15:0] pix_data, drop_cnt;
  gmii_rx_video #(.PIX_BYTES(PB)) dut (
    .rx_clk(rx_clk), .sys_rst(sys_rst), .id(id), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .line_start(line_start), .line_y(line_y), .pix_valid(pix_valid), .pix_data(pix_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .drop_cnt(drop_cnt)
  );
  always #5 rx_clk = ~rx_clk;
  int checks = 0, errors = 0;
  int ls_n = 0, ok_n = 0, err_n = 0, pix_n = 0, pushed_n = 0, n = 0;
  logic [15:0] exp_q[$];
  logic [7:0] b[0:2047];
  logic [15:0] drop_exp = 16'd0;
  logic [10:0] last_line = 11'd0;
  frame_t tbl[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge rx_clk) if (!sys_rst) begin
    if (line_start) ls_n++;
    if (frame_ok) ok_n++;
    if (frame_err) err_n++;
    if (frame_ok || frame_err) chk("ok_err_excl", 32'(frame_ok & frame_err), 32'd0);
    if (pix_valid) begin
      pix_n++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix_extra: got %h expected no pixel", pix_data);
      end else chk("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
    end
  end
  task automatic put(input logic dv, input logic er, input logic [7:0] d);
    rx_dv = dv;
    rx_er = er;
    rxd = d;
    @(posedge rx_clk);
    #1;
  endtask
  // reference CRC in reflected form; the FCS goes out complemented, low byte first
  function automatic logic [31:0] crc32(input int len);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++)
      for (int k = 0; k < 8; k++)
        c = (c >> 1) ^ ((c[0] ^ b[i][k]) ? 32'hEDB88320 : 32'h0);
    return ~c;
  endfunction
  task automatic build(input frame_t f);
    logic [31:0] c;
    for (int i = 0; i < HL; i++) b[i] = 8'(i * 7 + 3);
    b[0] = 8'h00; b[1] = 8'h23; b[2] = 8'h45; b[3] = 8'h67; b[4] = 8'h89; b[5] = f.mac_lo;
    b[12] = 8'h08; b[13] = 8'h00; b[23] = 8'h11;
    b[36] = f.port[15:8]; b[37] = f.port[7:0];
    b[42] = f.line[15:8]; b[43] = f.line[7:0];
    for (int i = 0; i < PB; i++) b[HL + i] = 8'(i);
    n = HL + PB;
    c = crc32(n);
    for (int k = 0; k < 4; k++) b[n + k] = c[8*k +: 8];
    n += 4;
    if (f.extra) begin
      b[n] = 8'hA5;
      n++;
    end
    if (f.flip >= 0) b[HL + f.flip] = b[HL + f.flip] ^ 8'hFF;
  endtask
  task automatic clear_counts();
    ls_n = 0; ok_n = 0; err_n = 0; pix_n = 0; pushed_n = 0;
    exp_q.delete();
  endtask
  task automatic end_checks(input frame_t f);
    chk("line_start_cnt", 32'(ls_n), 32'(f.acc));
    if (f.acc) last_line = f.line[10:0];
    chk("line_y", 32'(line_y), 32'(last_line));
    chk("frame_ok_cnt", 32'(ok_n), 32'(f.ok));
    chk("frame_err_cnt", 32'(err_n), 32'(f.err));
    if (f.err) drop_exp++;
    chk("drop_cnt", 32'(drop_cnt), 32'(drop_exp));
    chk("pix_cnt", 32'(pix_n), 32'(pushed_n));
    chk("pix_pending", 32'(exp_q.size()), 32'd0);
    clear_counts();
  endtask
  task automatic send(input frame_t f);
    bit alive = f.acc;
    build(f);
    id = f.id;
    repeat (7) put(1'b1, 1'b0, 8'h55);
    put(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < n; i++) begin
      logic er;
      if (i == f.cut_at) break;
      er = i == f.er_at;
      if (er) alive = 1'b0;
      if (alive && i >= HL && i < HL + PB && (i - HL) % 2 == 1) begin
        exp_q.push_back({b[i-1], b[i]});
        pushed_n++;
      end
      put(1'b1, er, b[i]);
    end
    repeat (f.gap) put(1'b0, 1'b0, 8'h00);
    @(negedge rx_clk);
    #1;
    end_checks(f);
  endtask
  initial begin
    tbl[0] = '{1'b0, 8'h02, 16'h3039, 16'd5,    -1, -1,       -1,       1'b0, 3, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h02, 16'h3039, 16'd6,    10, -1,       -1,       1'b0, 3, 1'b1, !CRC_ON, CRC_ON};
    tbl[2] = '{1'b0, 8'h03, 16'h3039, 16'd9,    -1, -1,       -1,       1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h02, 16'h3038, 16'd9,    -1, -1,       -1,       1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h01, 16'h3039, 16'd7,    -1, -1,       -1,       1'b0, 3, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h02, 16'h3039, 16'd9,    -1, -1,       -1,       1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h02, 16'h3039, 16'd8,    -1, HL + 100, -1,       1'b0, 3, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h02, 16'h3039, 16'd10,   -1, -1,       HL + 500, 1'b0, 1, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h02, 16'h3039, 16'hFFFF, -1, -1,       -1,       1'b0, 3, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 8'h02, 16'h3039, 16'd11,   -1, -1,       -1,       1'b1, 3, 1'b1, 1'b0, 1'b1};
    repeat (3) @(posedge rx_clk);
    #1;
    chk("rst_line_start", 32'(line_start), 32'd0);
    chk("rst_line_y", 32'(line_y), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_frame_ok", 32'(frame_ok), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    sys_rst = 1'b0;
    put(1'b0, 1'b0, 8'h00);
    put(1'b0, 1'b0, 8'h00);
    foreach (tbl[t]) send(tbl[t]);
    build(tbl[0]);
    id = 1'b0;
    repeat (7) put(1'b1, 1'b0, 8'h55);
    put(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < HL + 301; i++) begin
      if (i >= HL && (i - HL) % 2 == 1) begin
        exp_q.push_back({b[i-1], b[i]});
        pushed_n++;
      end
      put(1'b1, 1'b0, b[i]);
    end
    chk("prerst_pix_cnt", 32'(pix_n), 32'(pushed_n));
    chk("prerst_pending", 32'(exp_q.size()), 32'd0);
    #2 sys_rst = 1'b1;
    #1;
    chk("midrst_pix_valid", 32'(pix_valid), 32'd0);
    chk("midrst_pix_data", 32'(pix_data), 32'd0);
    chk("midrst_line_y", 32'(line_y), 32'd0);
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("midrst_flags", 32'({line_start, frame_ok, frame_err}), 32'd0);
    drop_exp = 16'd0;
    last_line = 11'd0;
    clear_counts();
    for (int i = HL + 301; i < HL + 305; i++) put(1'b1, 1'b0, b[i]);
    sys_rst = 1'b0;
    for (int i = HL + 305; i < n; i++) put(1'b1, 1'b0, b[i]);
    put(1'b0, 1'b0, 8'h00);
    @(negedge rx_clk);
    #1;
    chk("postrst_line_start", 32'(ls_n), 32'd0);
    chk("postrst_pix", 32'(pix_n), 32'd0);
    chk("postrst_ok", 32'(ok_n), 32'd0);
    chk("postrst_err", 32'(err_n), 32'd0);
    chk("postrst_drop_cnt", 32'(drop_cnt), 32'd0);
    clear_counts();
    send(tbl[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
